// File: rtl/ram_fetch_pkg.sv
// Shared defaults for the program-RAM fetch path (address/data widths, buffer depth, reset PC).
// Kept in one place so the RAM, fetcher and decoder agree.
package ram_fetch_pkg;
  localparam int ADDR_BITS_DEF  = 13;
  localparam int WIDTH_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int RESET_PC_DEF   = 0;
endpackage

// File: rtl/ram_fetch_fifo.sv
// Small synchronous FIFO buffering fetched {byte, address} entries.
// Flush beats push; pop alongside flush is legal (flush wins on state).
module ram_fetch_fifo
  import ram_fetch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int DW    = WIDTH_DEF + ADDR_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty;
  // When empty, keep showing the most recent head rather than a stale slot.
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (!empty) last_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end
endmodule

// File: rtl/ram_fetch.sv
// Sequential byte fetcher in front of the single-port program RAM: drives the address,
// absorbs the 1-cycle read latency and emits a valid/ready {byte, pc} stream with redirect.
module ram_fetch
  import ram_fetch_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 jump_valid,
  input  logic [ADDR_BITS-1:0] jump_addr,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  input  logic [WIDTH-1:0]     ram_do,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ADDR_BITS-1:0] out_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a byte transfers on a rising edge where out_valid & out_ready are both high;
  // out_valid never depends on out_ready and head data stays put until that transfer.
  logic [ADDR_BITS-1:0] pc;
  logic [ADDR_BITS-1:0] inflight_pc;
  logic                 inflight;
  logic [CW-1:0]        count;
  logic [CW:0]          used;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 issue;

  assign ram_addr  = pc;
  assign ram_we    = 1'b0;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~jump_valid;

  // Credits: buffered + in-flight entries after this cycle's pop must leave a free slot.
  assign used  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = en & ~jump_valid & (used < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= ADDR_BITS'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (jump_valid)  pc <= jump_addr;
      else if (issue)  pc <= pc + ADDR_BITS'(1);
      inflight    <= issue & ~jump_valid;
      inflight_pc <= pc;
    end
  end

  ram_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (WIDTH + ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_valid),
    .push  (push),
    .din   ({ram_do, inflight_pc}),
    .pop   (pop),
    .dout  ({out_data, out_pc}),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);
endmodule

// File: tb/tb_ram_fetch.sv
// Bench for ram_fetch: behavioural RAM with image mem[i] = i ^ 8'hA5, a stream scoreboard
// that expects strictly consecutive addresses, and directed + randomized phases.
module tb_ram_fetch;
  localparam int AW       = 13;
  localparam int DW       = 8;
  localparam int RESET_PC = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          jump_valid = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_do;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard state
  bit            mon_on = 1'b0;
  logic [AW-1:0] exp_pc = '0;
  int            rx_cnt = 0;
  logic [AW-1:0] rx_q[$];
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  ram_fetch #(
    .ADDR_BITS  (AW),
    .WIDTH      (DW),
    .FIFO_DEPTH (2),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_do     (ram_do),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_pc     (out_pc)
  );

  // program RAM: synchronous read, data = mem[address of previous edge]
  logic [DW-1:0] rom [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) rom[i] = DW'(i) ^ 8'hA5;
  always @(posedge clk) ram_do <= rom[ram_addr];

  function automatic logic [DW-1:0] image_byte(input logic [AW-1:0] a);
    return DW'(a) ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Stream scoreboard: every accepted byte must be the next address and its image byte.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (out_valid && out_ready) begin
        check("stream_pc", out_pc, exp_pc);
        check("stream_data", out_data, image_byte(exp_pc));
        rx_q.push_back(out_pc);
        rx_cnt++;
        exp_pc = exp_pc + AW'(1);
      end
      if (jump_valid) exp_pc = jump_addr;
    end
  end

  initial begin
    int            rx0;
    logic [AW-1:0] held;
    logic [AW-1:0] prev_addr;
    logic [3:0]    en_pat;

    // reset state
    #2 rst = 1'b1;
    tick();
    tick();
    sample();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_pc", out_pc, 0);
    check("rst_ram_addr", ram_addr, RESET_PC);
    check("rst_ram_we", ram_we, 0);

    // T1: startup latency and unbroken stream
    tick();
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    exp_pc = AW'(RESET_PC); mon_on = 1'b1;
    sample(); check("t1_c0_valid", out_valid, 0);
    tick(); sample(); check("t1_c1_valid", out_valid, 0);
    tick(); sample(); check("t1_c2_valid", out_valid, 1);
    check("t1_first_pc", out_pc, RESET_PC);
    for (int i = 0; i < 8; i++) begin
      tick(); sample(); check("t1_no_bubble", out_valid, 1);
    end
    check("t1_rx_cnt", rx_cnt, 9);

    // T2: backpressure freezes head and stops the address
    tick();
    out_ready = 1'b0;
    held = exp_pc;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t2_hold_pc", out_pc, held);
      check("t2_hold_data", out_data, image_byte(held));
      check("t2_ram_addr", ram_addr, held + AW'(2));
      tick();
    end
    out_ready = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 6; i++) begin
      sample(); check("t2_resume_valid", out_valid, 1);
      tick();
    end
    check("t2_resume_cnt", rx_cnt - rx0, 6);

    // T3a: jump with a read in flight and consumer stalled
    out_ready = 1'b0; jump_valid = 1'b1; jump_addr = AW'('h100);
    sample();
    tick(); jump_valid = 1'b0;
    sample(); check("t3a_j1_valid", out_valid, 0);
    tick(); sample(); check("t3a_j2_valid", out_valid, 0);
    tick(); sample(); check("t3a_j3_valid", out_valid, 1);
    check("t3a_pc", out_pc, 'h100);
    check("t3a_data", out_data, 'hA5);
    tick(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // T3b: jump in the same cycle as a pop
    rx0 = rx_cnt;
    jump_valid = 1'b1; jump_addr = AW'('h200);
    sample(); check("t3b_pop_in_jump", out_valid, 1);
    tick(); jump_valid = 1'b0;
    check("t3b_kept_byte", rx_cnt - rx0, 1);
    sample(); check("t3b_j1_valid", out_valid, 0);
    tick(); sample(); check("t3b_j2_valid", out_valid, 0);
    tick(); sample(); check("t3b_j3_valid", out_valid, 1);
    check("t3b_pc", out_pc, 'h200);
    tick();

    // T4: FIFO full, then jump near the top of memory and wrap
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin sample(); tick(); end
    jump_valid = 1'b1; jump_addr = AW'('h1FFE);
    sample();
    tick(); jump_valid = 1'b0; out_ready = 1'b1;
    rx_q.delete();
    exp_q = '{AW'('h1FFE), AW'('h1FFF), AW'('h0000), AW'('h0001)};
    for (int i = 0; i < 20 && rx_q.size() < 4; i++) begin sample(); tick(); end
    check("t4_rx_size", rx_q.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check("t4_wrap_pc", rx_q[i], exp_q[i]);

    // T5: en toggling 1,0,0,1 with random ready and occasional random jumps
    en_pat = 4'b1001;
    rx0 = rx_cnt;
    prev_addr = ram_addr;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!en && !jump_valid) check("t5_pc_hold", ram_addr, prev_addr);
      prev_addr  = ram_addr;
      en         = en_pat[(i / 3) % 4];
      out_ready  = ($urandom_range(0, 3) != 0);
      jump_valid = ($urandom_range(0, 49) == 0);
      jump_addr  = AW'($urandom);
    end
    tick();
    en = 1'b0; jump_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    sample(); check("t5_drained", out_valid, 0);
    check("t5_progress", (rx_cnt - rx0) > 20, 1);

    // T6: asynchronous reset mid-stream
    tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_pc", out_pc, 0);
    check("t6_async_data", out_data, 0);
    check("t6_async_ram_addr", ram_addr, RESET_PC);
    exp_pc = AW'(RESET_PC);
    rx_q.delete();
    tick();
    rst = 1'b0;
    sample(); check("t6_c0_valid", out_valid, 0);
    tick(); sample(); check("t6_c1_valid", out_valid, 0);
    tick(); sample(); check("t6_c2_valid", out_valid, 1);
    check("t6_first_pc", out_pc, RESET_PC);
    check("t6_ram_we", ram_we, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_rx_size", rx_q.size() >= 1, 1);
    if (rx_q.size() >= 1) check("t6_rx_first", rx_q[0], RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
